// File: rtl/clic_gateway_arb.sv
// CLIC upstream stage: gates raw interrupt lines into pending bits, ranks
// enabled pending sources and offers the winner on a registered valid/ready port.
module clic_gateway_arb #(
  parameter  int unsigned N_SOURCE   = 256,
  parameter  int unsigned INTCTLBITS = 8,
  localparam int unsigned SRC_W      = $clog2(N_SOURCE)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_SOURCE-1:0]     intr_src_i,
  input  logic [N_SOURCE-1:0]     ie_i,
  input  logic [N_SOURCE-1:0]     trig_edge_i,
  input  logic [N_SOURCE-1:0]     trig_pol_i,
  input  logic [N_SOURCE*8-1:0]   intctl_i,
  input  logic [N_SOURCE*2-1:0]   priv_i,
  input  logic [N_SOURCE-1:0]     shv_i,
  output logic [N_SOURCE-1:0]     ip_o,
  output logic                    clic_irq_valid_o,
  input  logic                    clic_irq_ready_i,
  output logic [SRC_W-1:0]        clic_irq_id_o,
  output logic [7:0]              clic_irq_level_o,
  output logic                    clic_irq_shv_o,
  output logic [1:0]              clic_irq_priv_o
);

  typedef enum logic [1:0] {IDLE, OFFER, GAP} state_t;

  localparam logic [7:0]  LVL_FILL = 8'((1 << (8 - INTCTLBITS)) - 1);
  localparam int unsigned LEAVES   = 1 << SRC_W;
  localparam int unsigned NODES    = 2 * LEAVES - 1;

  state_t              state, state_nx;
  logic [N_SOURCE-1:0] act, hist, ip, cand, claim_clr;
  logic                load, claim, retract;

  logic [9:0]          node_key [NODES];
  logic                node_vld [NODES];
  logic [SRC_W-1:0]    node_id  [NODES];
  logic [9:0]          win_key;
  logic [SRC_W-1:0]    win_id;
  logic                any_cand;

  assign act  = intr_src_i ^ trig_pol_i;
  assign cand = ip & ie_i;
  assign ip_o = ip;

  always_comb begin
    claim_clr = '0;
    if (claim) claim_clr[clic_irq_id_o] = 1'b1;
  end

  // Edge sources: a fresh edge in the claim cycle outranks the claim's clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist <= '0;
      ip   <= '0;
    end else begin
      hist <= act;
      ip   <= (trig_edge_i & ((ip & ~claim_clr) | (act & ~hist))) | (~trig_edge_i & act);
    end
  end

  // Heap-indexed comparison tree; on equal keys the right (higher-ID) child wins.
  always_comb begin : rank_tree
    logic [1:0]  pm;
    logic        take_r;
    int unsigned n;
    pm     = '0;
    take_r = 1'b0;
    n      = 0;
    for (int unsigned j = 0; j < NODES; j++) begin
      node_key[j] = '0;
      node_vld[j] = 1'b0;
      node_id[j]  = '0;
    end
    for (int unsigned i = 0; i < N_SOURCE; i++) begin
      pm = priv_i[2*i +: 2];
      if (pm == 2'b10) pm = 2'b00;
      node_vld[LEAVES-1+i] = cand[i];
      node_key[LEAVES-1+i] = {pm, intctl_i[8*i +: 8] | LVL_FILL};
      node_id[LEAVES-1+i]  = SRC_W'(i);
    end
    for (int unsigned k = 0; k < LEAVES - 1; k++) begin
      n      = LEAVES - 2 - k;
      take_r = node_vld[2*n+2] &&
               (!node_vld[2*n+1] || (node_key[2*n+2] >= node_key[2*n+1]));
      node_vld[n] = node_vld[2*n+1] || node_vld[2*n+2];
      node_key[n] = take_r ? node_key[2*n+2] : node_key[2*n+1];
      node_id[n]  = take_r ? node_id[2*n+2]  : node_id[2*n+1];
    end
  end

  assign any_cand = node_vld[0];
  assign win_key  = node_key[0];
  assign win_id   = node_id[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_cand) state_nx = OFFER;
      OFFER:   if (claim) state_nx = GAP;
               else if (retract) state_nx = IDLE;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load    = (state == IDLE) && any_cand;
    claim   = (state == OFFER) && clic_irq_ready_i;
    retract = (state == OFFER) && !clic_irq_ready_i && !cand[clic_irq_id_o];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clic_irq_valid_o <= 1'b0;
      clic_irq_id_o    <= '0;
      clic_irq_level_o <= '0;
      clic_irq_shv_o   <= 1'b0;
      clic_irq_priv_o  <= '0;
    end else if (load) begin
      clic_irq_valid_o <= 1'b1;
      clic_irq_id_o    <= win_id;
      clic_irq_level_o <= win_key[7:0];
      clic_irq_shv_o   <= shv_i[win_id];
      clic_irq_priv_o  <= win_key[9:8];
    end else if (claim || retract) begin
      clic_irq_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clic_gateway_arb.sv
// Bench for clic_gateway_arb: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of gateway, ranking and handoff.
module tb_clic_gateway_arb;

  localparam int N = 16;
  localparam int B = 3;
  localparam int W = $clog2(N);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     src, ie, edg, pol, shv, ip_o;
  logic [N*8-1:0]   intctl;
  logic [N*2-1:0]   priv;
  logic             valid, ready;
  logic [W-1:0]     id;
  logic [7:0]       level;
  logic             shv_o;
  logic [1:0]       priv_o;

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model state
  logic [N-1:0] m_ip, m_hist;
  bit           m_valid, m_gap;
  int           m_id, m_lvl, m_priv;
  bit           m_shv;

  clic_gateway_arb #(.N_SOURCE(N), .INTCTLBITS(B)) dut (
    .clk_i(clk), .rst_ni(rst_n), .intr_src_i(src), .ie_i(ie),
    .trig_edge_i(edg), .trig_pol_i(pol), .intctl_i(intctl), .priv_i(priv),
    .shv_i(shv), .ip_o(ip_o), .clic_irq_valid_o(valid), .clic_irq_ready_i(ready),
    .clic_irq_id_o(id), .clic_irq_level_o(level), .clic_irq_shv_o(shv_o),
    .clic_irq_priv_o(priv_o)
  );

  always #5 clk = ~clk;

  function automatic int eff_priv(int i);
    logic [1:0] p;
    p = priv[2*i +: 2];
    return (p == 2'b10) ? 0 : int'(p);
  endfunction

  function automatic int eff_lvl(int i);
    return int'(intctl[8*i +: 8]) | ((1 << (8 - B)) - 1);
  endfunction

  task automatic model_reset();
    m_ip = '0; m_hist = '0; m_valid = 0; m_gap = 0;
    m_id = 0; m_lvl = 0; m_priv = 0; m_shv = 0;
  endtask

  task automatic clear_cfg();
    src = '0; ie = '0; edg = '0; pol = '0; shv = '0;
    intctl = '0; priv = '0; ready = 1'b0;
  endtask

  // Advance one clock; the model evaluates on the inputs held across the edge.
  task automatic step();
    logic [N-1:0] act, nip;
    bit claim, retract;
    int best, bkey, key;
    act     = src ^ pol;
    claim   = m_valid && ready;
    retract = m_valid && !ready && !(m_ip[m_id] && ie[m_id]);
    for (int i = 0; i < N; i++)
      nip[i] = edg[i] ? ((act[i] && !m_hist[i]) || (m_ip[i] && !(claim && m_id == i))) : act[i];
    best = -1; bkey = -1;
    for (int i = 0; i < N; i++) begin
      key = eff_priv(i) * 256 + eff_lvl(i);
      if (m_ip[i] && ie[i] && key >= bkey) begin bkey = key; best = i; end
    end
    @(posedge clk); #1;
    if (m_gap) m_gap = 0;
    else if (!m_valid) begin
      if (best >= 0) begin
        m_valid = 1; m_id = best; m_lvl = eff_lvl(best);
        m_priv = eff_priv(best); m_shv = shv[best];
      end
    end else if (claim) begin m_valid = 0; m_gap = 1; end
    else if (retract) m_valid = 0;
    m_ip = nip; m_hist = act;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_cfg();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (ip_o !== '0) $display("FAIL reset_ip got %h want 0", ip_o); else n_pass++;
    n_checks++; if ({valid, id, level, shv_o, priv_o} !== '0)
      $display("FAIL reset_out got v%b id%0d l%h s%b p%b want all 0", valid, id, level, shv_o, priv_o); else n_pass++;
    step();
    n_checks++; if (valid !== 1'b0) $display("FAIL reset_idle valid got %b want 0", valid); else n_pass++;
  endtask

  task automatic test_level_latency();
    apply_reset();
    ie[5] = 1; intctl[40 +: 8] = 8'h80; priv[10 +: 2] = 2'b11; shv[5] = 1; src[5] = 1;
    step();
    n_checks++; if (ip_o[5] !== 1'b1 || valid !== 1'b0)
      $display("FAIL lvl_ip got ip5=%b v=%b want ip5=1 v=0", ip_o[5], valid); else n_pass++;
    step();
    n_checks++; if ({valid, id, level, priv_o, shv_o} !== {1'b1, 4'd5, 8'h9F, 2'b11, 1'b1})
      $display("FAIL lvl_offer got v%b id%0d l%h p%b s%b want v1 id5 l9f p11 s1", valid, id, level, priv_o, shv_o); else n_pass++;
  endtask

  task automatic test_edge_tie();
    apply_reset();
    ie[3] = 1; ie[9] = 1; edg[3] = 1; edg[9] = 1;
    intctl[24 +: 8] = 8'h40; intctl[72 +: 8] = 8'h40;
    priv[6 +: 2] = 2'b11; priv[18 +: 2] = 2'b11;
    src[3] = 1; src[9] = 1;
    step();
    src = '0;
    step();
    n_checks++; if (valid !== 1'b1 || id !== 4'd9) $display("FAIL tie_first got v%b id%0d want v1 id9", valid, id); else n_pass++;
    ready = 1;
    step();
    n_checks++; if (ip_o[9] !== 1'b0 || ip_o[3] !== 1'b1 || valid !== 1'b0)
      $display("FAIL tie_claim got ip9=%b ip3=%b v=%b want 0 1 0", ip_o[9], ip_o[3], valid); else n_pass++;
    ready = 0;
    step();
    n_checks++; if (valid !== 1'b0) $display("FAIL tie_gap valid got %b want 0", valid); else n_pass++;
    step();
    n_checks++; if (valid !== 1'b1 || id !== 4'd3) $display("FAIL tie_second got v%b id%0d want v1 id3", valid, id); else n_pass++;
  endtask

  task automatic test_priv_rank();
    apply_reset();
    ie[7] = 1; priv[14 +: 2] = 2'b01; intctl[56 +: 8] = 8'hF0; src[7] = 1;
    ie[2] = 1; priv[4 +: 2]  = 2'b11; intctl[16 +: 8] = 8'h10; src[2] = 1;
    step(); step();
    n_checks++; if ({valid, id, priv_o, level} !== {1'b1, 4'd2, 2'b11, 8'h1F})
      $display("FAIL priv_m got v%b id%0d p%b l%h want v1 id2 p11 l1f", valid, id, priv_o, level); else n_pass++;
    priv[4 +: 2] = 2'b10;
    ready = 1; step(); ready = 0; step(); step();
    n_checks++; if ({valid, id, priv_o, level} !== {1'b1, 4'd7, 2'b01, 8'hFF})
      $display("FAIL priv_s got v%b id%0d p%b l%h want v1 id7 p01 lff", valid, id, priv_o, level); else n_pass++;
    ready = 1; ie[7] = 0; step(); ready = 0; step(); step();
    n_checks++; if ({valid, id, priv_o, level} !== {1'b1, 4'd2, 2'b00, 8'h1F})
      $display("FAIL priv_rsvd got v%b id%0d p%b l%h want v1 id2 p00 l1f", valid, id, priv_o, level); else n_pass++;
  endtask

  task automatic test_retract();
    apply_reset();
    ie[4] = 1; priv[8 +: 2] = 2'b11; intctl[32 +: 8] = 8'h20; src[4] = 1;
    step(); step();
    n_checks++; if (valid !== 1'b1 || id !== 4'd4) $display("FAIL ret_offer got v%b id%0d want v1 id4", valid, id); else n_pass++;
    src[4] = 0;
    step();
    n_checks++; if (ip_o[4] !== 1'b0 || valid !== 1'b1) $display("FAIL ret_ipdrop got ip4=%b v=%b want 0 1", ip_o[4], valid); else n_pass++;
    step();
    n_checks++; if (valid !== 1'b0 || id !== 4'd4) $display("FAIL ret_fall got v%b id%0d want v0 id4", valid, id); else n_pass++;
    src[4] = 1; ie[6] = 1; edg[6] = 1; src[6] = 1;
    step();
    src[6] = 0;
    step();
    n_checks++; if (valid !== 1'b1 || id !== 4'd4) $display("FAIL ret_reoffer got v%b id%0d want v1 id4", valid, id); else n_pass++;
    ie[4] = 0; ready = 1;
    step();
    ready = 0;
    n_checks++; if (valid !== 1'b0 || ip_o[4] !== 1'b1) $display("FAIL ret_claimwins got v%b ip4=%b want v0 ip4=1", valid, ip_o[4]); else n_pass++;
    step();
    n_checks++; if (valid !== 1'b0) $display("FAIL ret_gap valid got %b want 0", valid); else n_pass++;
    step();
    n_checks++; if (valid !== 1'b1 || id !== 4'd6) $display("FAIL ret_next got v%b id%0d want v1 id6", valid, id); else n_pass++;
  endtask

  task automatic test_repulse();
    apply_reset();
    ie[1] = 1; edg[1] = 1; priv[2 +: 2] = 2'b11; src[1] = 1;
    step();
    src[1] = 0;
    step();
    n_checks++; if (valid !== 1'b1 || id !== 4'd1) $display("FAIL rep_offer got v%b id%0d want v1 id1", valid, id); else n_pass++;
    src[1] = 1; ready = 1;
    step();
    n_checks++; if (ip_o[1] !== 1'b1 || valid !== 1'b0) $display("FAIL rep_setwins got ip1=%b v=%b want 1 0", ip_o[1], valid); else n_pass++;
    src[1] = 0; ready = 0;
    step(); step();
    n_checks++; if (valid !== 1'b1 || id !== 4'd1) $display("FAIL rep_again got v%b id%0d want v1 id1", valid, id); else n_pass++;
  endtask

  task automatic test_reset_mid_offer();
    apply_reset();
    ie[12] = 1; priv[24 +: 2] = 2'b11; src[12] = 1;
    ie[8] = 1; edg[8] = 1; pol[8] = 1; src[8] = 1;
    ie[10] = 1; edg[10] = 1; src[10] = 1;
    step(); step();
    n_checks++; if (valid !== 1'b1 || id !== 4'd12) $display("FAIL rmo_offer got v%b id%0d want v1 id12", valid, id); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({valid, id, level, shv_o, priv_o} !== '0 || ip_o !== '0)
      $display("FAIL rmo_async got v%b id%0d l%h ip%h want all 0", valid, id, level, ip_o); else n_pass++;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++; if (ip_o[8] !== 1'b0 || ip_o[10] !== 1'b1 || ip_o !== m_ip)
      $display("FAIL rmo_release got ip%h want %h (ip8=0 ip10=1)", ip_o, m_ip); else n_pass++;
    step();
    n_checks++; if (valid !== 1'b1 || id !== 4'd12) $display("FAIL rmo_rebuild got v%b id%0d want v1 id12", valid, id); else n_pass++;
  endtask

  task automatic rand_cfg();
    ie = N'($urandom); shv = N'($urandom);
    priv = {$urandom};
    for (int i = 0; i < N; i++) intctl[8*i +: 8] = 8'($urandom);
  endtask

  task automatic test_random();
    apply_reset();
    edg = N'($urandom); pol = N'($urandom); src = pol;
    rand_cfg();
    for (int c = 0; c < 400; c++) begin
      if (c % 60 == 59) rand_cfg();
      src   = src ^ (N'($urandom) & N'($urandom) & N'($urandom));
      ready = ($urandom_range(0, 2) == 0);
      step();
      n_checks++; if (ip_o !== m_ip) $display("FAIL rnd_ip c%0d got %h want %h", c, ip_o, m_ip); else n_pass++;
      n_checks++; if (valid !== m_valid) $display("FAIL rnd_valid c%0d got %b want %b", c, valid, m_valid); else n_pass++;
      n_checks++; if (id !== W'(m_id) || level !== 8'(m_lvl))
        $display("FAIL rnd_idlvl c%0d got id%0d l%h want id%0d l%h", c, id, level, m_id, m_lvl); else n_pass++;
      n_checks++; if (priv_o !== 2'(m_priv) || shv_o !== m_shv)
        $display("FAIL rnd_attr c%0d got p%b s%b want p%b s%b", c, priv_o, shv_o, 2'(m_priv), m_shv); else n_pass++;
    end
  endtask

  initial begin
    clear_cfg();
    model_reset();
    test_reset();
    test_level_latency();
    test_edge_tie();
    test_priv_rank();
    test_retract();
    test_repulse();
    test_reset_mid_offer();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
